// File: rtl/ctx_switch_unit.sv
// ctx_switch_unit -- context save/restore sequencer in front of data memory.
//
// Purpose:
//   On a save request it writes the leaving process's PC and its registers
//   r1..NSAVE into that process's slot in data memory, one word per cycle.
//   On a restore request it reads the slot back, writes r1..NSAVE into the
//   register file, and hands the saved PC to fetch with a pc_load strobe.
//   Slot layout: base+0 = PC, base+k = rk (k=1..NSAVE),
//   [base+NSAVE+1 = XOR checksum when CTX_CHECKSUM_EN is defined].
//
// Optional feature macro: CTX_CHECKSUM_EN (adds checksum word and chk_err).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_save/_restore   one-cycle requests, proc_id sampled with them
//   pc_in                 saved PC from data memory (saidaPC)
//   reg_raddr/reg_rdata   register file read port (combinational read)
//   reg_we/waddr/wdata    register file write port
//   mem_addr/wdata/we/re  data memory port; mem_rdata is combinational
//   pc_out, pc_load       restored PC and its one-cycle valid strobe
//   busy, done, err       status: working, completion pulse, rejected request
//   chk_err               checksum mismatch (CTX_CHECKSUM_EN only)
//   dbg_state             current FSM state for observation
//
// Handshake: a start pulse is accepted only in IDLE; pulses seen in any other
// state are dropped silently. done pulses for exactly one cycle in FIN.
module ctx_switch_unit #(
  parameter int DATA_W   = 32,
  parameter int NSAVE    = 7,
  parameter int NUM_PROC = 4,
  parameter int CTX_BASE = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_save,
  input  logic              start_restore,
  input  logic [1:0]        proc_id,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [4:0]        reg_raddr,
  output logic              reg_we,
  output logic [4:0]        reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pc_out,
  output logic              pc_load,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef CTX_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic [1:0]        dbg_state
);

`ifdef CTX_CHECKSUM_EN
  localparam int STRIDE = NSAVE + 2;
`else
  localparam int STRIDE = NSAVE + 1;
`endif
  localparam logic [5:0] K_LAST = 6'(STRIDE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [5:0]        r_k;
  logic [31:0]       r_base;
  logic [DATA_W-1:0] r_pc;
  logic              r_err;
  logic              r_restore;
  logic              w_proc_ok;
  logic              w_any_start;
  logic              w_accept;
  logic              w_reject;
  logic [31:0]       w_base;
`ifdef CTX_CHECKSUM_EN
  logic [DATA_W-1:0] r_xor;
  logic              r_chk_bad;
`endif

  assign w_proc_ok   = 32'(proc_id) < 32'(NUM_PROC);
  assign w_any_start = start_save | start_restore;
  // Exactly one start with a valid slot is accepted; anything else that
  // shows up in IDLE is rejected with err.
  assign w_accept    = (r_state == S_IDLE) && (start_save ^ start_restore) && w_proc_ok;
  assign w_reject    = (r_state == S_IDLE) && w_any_start && !w_accept;
  assign w_base      = 32'(CTX_BASE) + 32'(proc_id) * 32'(STRIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_base    <= '0;
      r_pc      <= '0;
      r_err     <= 1'b0;
      r_restore <= 1'b0;
`ifdef CTX_CHECKSUM_EN
      r_xor     <= '0;
      r_chk_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_err   <= w_reject;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_k       <= '0;
            r_base    <= w_base;
            r_restore <= start_restore;
`ifdef CTX_CHECKSUM_EN
            r_xor     <= '0;
            r_chk_bad <= 1'b0;
`endif
          end
        end
        S_SAVE: begin
          r_k <= r_k + 6'd1;
`ifdef CTX_CHECKSUM_EN
          r_xor <= r_xor ^ mem_wdata;
`endif
        end
        S_RESTORE: begin
          r_k <= r_k + 6'd1;
          if (r_k == 6'd0) r_pc <= mem_rdata;
`ifdef CTX_CHECKSUM_EN
          r_xor <= r_xor ^ mem_rdata;
          // Last word read is the stored checksum; compare against the XOR
          // of everything read before it.
          if ((r_k == K_LAST) && (mem_rdata != r_xor)) r_chk_bad <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    reg_raddr = '0;
    reg_we    = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    pc_load   = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = start_save ? S_SAVE : S_RESTORE;
      end
      S_SAVE: begin
        mem_we   = 1'b1;
        mem_addr = r_base + 32'(r_k);
        if (r_k == 6'd0) begin
          mem_wdata = pc_in;
`ifdef CTX_CHECKSUM_EN
        end else if (r_k == K_LAST) begin
          mem_wdata = r_xor;
`endif
        end else begin
          reg_raddr = r_k[4:0];
          mem_wdata = reg_rdata;
        end
        if (r_k == K_LAST) w_next = S_FIN;
      end
      S_RESTORE: begin
        mem_re   = 1'b1;
        mem_addr = r_base + 32'(r_k);
        if ((r_k != 6'd0) && (r_k <= 6'(NSAVE))) begin
          reg_we    = 1'b1;
          reg_waddr = r_k[4:0];
          reg_wdata = mem_rdata;
        end
        if (r_k == K_LAST) w_next = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
`ifdef CTX_CHECKSUM_EN
        pc_load = r_restore && !r_chk_bad;
`else
        pc_load = r_restore;
`endif
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state == S_SAVE) || (r_state == S_RESTORE);
  assign err       = r_err;
  assign pc_out    = r_pc;
  assign dbg_state = r_state;
`ifdef CTX_CHECKSUM_EN
  assign chk_err   = (r_state == S_FIN) && r_chk_bad;
`endif

endmodule

// File: tb/tb_ctx_switch_unit.sv
module tb_ctx_switch_unit;

`ifdef CTX_CHECKSUM_EN
  localparam int STRIDE = 9;
`else
  localparam int STRIDE = 8;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (NUM_PROC = 4) ----------------
  logic        start_save = 0, start_restore = 0;
  logic [1:0]  proc_id = 0;
  logic [31:0] pc_in = 0;
  logic [31:0] reg_rdata, mem_rdata, reg_wdata, mem_addr, mem_wdata, pc_out;
  logic [4:0]  reg_raddr, reg_waddr;
  logic        reg_we, mem_we, mem_re, pc_load, busy, done, err;
  logic [1:0]  dbg_state;
`ifdef CTX_CHECKSUM_EN
  logic        chk_err;
`endif

  ctx_switch_unit u_dut (
    .clk(clk), .reset(reset), .start_save(start_save), .start_restore(start_restore),
    .proc_id(proc_id), .pc_in(pc_in), .reg_rdata(reg_rdata), .reg_raddr(reg_raddr),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .pc_out(pc_out), .pc_load(pc_load), .busy(busy), .done(done), .err(err),
`ifdef CTX_CHECKSUM_EN
    .chk_err(chk_err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (NUM_PROC = 3) ----------------
  logic        s3_save = 0, s3_restore = 0;
  logic [1:0]  s3_pid = 0;
  logic [31:0] s3_reg_wdata, s3_mem_addr, s3_mem_wdata, s3_pc_out;
  logic [4:0]  s3_reg_raddr, s3_reg_waddr;
  logic        s3_reg_we, s3_mem_we, s3_mem_re, s3_pc_load, s3_busy, s3_done, s3_err;
  logic [1:0]  s3_dbg;
`ifdef CTX_CHECKSUM_EN
  logic        s3_chk_err;
`endif

  ctx_switch_unit #(.NUM_PROC(3)) u_dut3 (
    .clk(clk), .reset(reset), .start_save(s3_save), .start_restore(s3_restore),
    .proc_id(s3_pid), .pc_in(32'h0), .reg_rdata(32'h0), .reg_raddr(s3_reg_raddr),
    .reg_we(s3_reg_we), .reg_waddr(s3_reg_waddr), .reg_wdata(s3_reg_wdata),
    .mem_addr(s3_mem_addr), .mem_wdata(s3_mem_wdata), .mem_we(s3_mem_we),
    .mem_re(s3_mem_re), .mem_rdata(32'h0), .pc_out(s3_pc_out), .pc_load(s3_pc_load),
    .busy(s3_busy), .done(s3_done), .err(s3_err),
`ifdef CTX_CHECKSUM_EN
    .chk_err(s3_chk_err),
`endif
    .dbg_state(s3_dbg)
  );

  // ---------------- environment: data memory + register source ----------------
  logic [31:0] mem [64];
  logic        bd_we = 0;
  logic [5:0]  bd_addr = 0;
  logic [31:0] bd_data = 0;

  assign mem_rdata = mem[mem_addr[5:0]];
  // Register k reads as 0x100+k.
  assign reg_rdata = 32'h100 + {27'b0, reg_raddr};

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    if (bd_we)  mem[bd_addr] <= bd_data;
  end

  // ---------------- monitor ----------------
  logic [31:0] wa_q[$], wd_q[$], rd_q[$];
  logic [4:0]  ra_q[$];
  logic [31:0] exp_q[$];
  int cyc = 0, busy_cnt, done_cnt, err_cnt, pl_cnt, pl_bad, re_cnt, excl_bad;
  int chk_cnt, chk_bad, last_busy, done_cyc;

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin wa_q.push_back(mem_addr); wd_q.push_back(mem_wdata); end
    if (reg_we) begin ra_q.push_back(reg_waddr); rd_q.push_back(reg_wdata); end
    if (mem_re) re_cnt++;
    if (busy) begin busy_cnt++; last_busy = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (pc_load) pl_cnt++;
    if (pc_load && !done) pl_bad++;
    if ((mem_we && mem_re) || (mem_we && reg_we)) excl_bad++;
`ifdef CTX_CHECKSUM_EN
    if (chk_err) chk_cnt++;
    if (chk_err && !done) chk_bad++;
`endif
  end

  int checks = 0, errors = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); ra_q.delete(); rd_q.delete(); exp_q.delete();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0; pl_cnt = 0; pl_bad = 0; re_cnt = 0;
    excl_bad = 0; chk_cnt = 0; chk_bad = 0; last_busy = -1; done_cyc = -2;
  endtask

  task automatic pulse(input logic ss, input logic sr, input logic [1:0] pid);
    @(posedge clk); #1;
    start_save = ss; start_restore = sr; proc_id = pid;
    @(posedge clk); #1;
    start_save = 0; start_restore = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_slot(input logic [31:0] pc);
    logic [31:0] x;
    x = pc;
    exp_q.push_back(pc);
    for (int i = 1; i <= 7; i++) begin
      exp_q.push_back(32'h100 + 32'(i));
      x = x ^ (32'h100 + 32'(i));
    end
`ifdef CTX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    wait_cycles(3);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_we, mem_re, reg_we, pc_load, busy, done, err, mem_addr, mem_wdata,
           reg_raddr, reg_waddr, reg_wdata, pc_out, dbg_state} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: we=%b re=%b rwe=%b pl=%b busy=%b done=%b err=%b addr=%h wd=%h pc=%h, expected all 0",
                 i, mem_we, mem_re, reg_we, pc_load, busy, done, err, mem_addr, mem_wdata, pc_out);
      end
    end
  endtask

  task automatic test_save();
    clear_mon();
    pc_in = 32'h2B0;
    push_slot(32'h2B0);
    pulse(1, 0, 2'd1);
    wait_cycles(14);
    checks++;
    if (wa_q.size() != STRIDE) begin
      errors++; $display("FAIL save_nwrites: got %0d expected %0d", wa_q.size(), STRIDE);
    end
    for (int i = 0; i < STRIDE && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'(24 + STRIDE + i) || wd_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL save_word%0d: addr=%0d data=%h expected addr=%0d data=%h",
                 i, wa_q[i], wd_q[i], 24 + STRIDE + i, exp_q[i]);
      end
    end
    checks++;
    if (busy_cnt != STRIDE || done_cnt != 1 || done_cyc != last_busy + 1) begin
      errors++;
      $display("FAIL save_timing: busy=%0d done=%0d done_after_busy=%0d expected busy=%0d done=1 gap=1",
               busy_cnt, done_cnt, done_cyc - last_busy, STRIDE);
    end
    checks++;
    if (ra_q.size() != 0 || re_cnt != 0 || pl_cnt != 0 || err_cnt != 0 || excl_bad != 0) begin
      errors++;
      $display("FAIL save_side: reg_we=%0d mem_re=%0d pc_load=%0d err=%0d excl=%0d expected all 0",
               ra_q.size(), re_cnt, pl_cnt, err_cnt, excl_bad);
    end
  endtask

  task automatic test_restore();
    clear_mon();
    pc_in = 32'h0;
    pulse(0, 1, 2'd1);
    wait_cycles(14);
    checks++;
    if (ra_q.size() != 7) begin
      errors++; $display("FAIL restore_nregs: got %0d expected 7", ra_q.size());
    end
    for (int i = 0; i < 7 && i < ra_q.size(); i++) begin
      checks++;
      if (ra_q[i] !== 5'(i + 1) || rd_q[i] !== 32'h101 + 32'(i)) begin
        errors++;
        $display("FAIL restore_reg%0d: waddr=%0d data=%h expected waddr=%0d data=%h",
                 i, ra_q[i], rd_q[i], i + 1, 32'h101 + 32'(i));
      end
    end
    checks++;
    if (pc_out !== 32'h2B0) begin
      errors++; $display("FAIL restore_pc: got %h expected 2b0", pc_out);
    end
    checks++;
    if (pl_cnt != 1 || pl_bad != 0 || done_cnt != 1 || busy_cnt != STRIDE) begin
      errors++;
      $display("FAIL restore_strobes: pc_load=%0d stray=%0d done=%0d busy=%0d expected 1 0 1 %0d",
               pl_cnt, pl_bad, done_cnt, busy_cnt, STRIDE);
    end
    checks++;
    if (wa_q.size() != 0 || re_cnt != STRIDE || chk_cnt != 0 || excl_bad != 0) begin
      errors++;
      $display("FAIL restore_mem: mem_we=%0d mem_re=%0d chk=%0d excl=%0d expected 0 %0d 0 0",
               wa_q.size(), re_cnt, chk_cnt, excl_bad, STRIDE);
    end
  endtask

  task automatic test_both_starts();
    clear_mon();
    pulse(1, 1, 2'd1);
    wait_cycles(4);
    checks++;
    if (err_cnt != 1 || busy_cnt != 0 || wa_q.size() != 0 || re_cnt != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL both_starts: err=%0d busy=%0d we=%0d re=%0d done=%0d expected 1 0 0 0 0",
               err_cnt, busy_cnt, wa_q.size(), re_cnt, done_cnt);
    end
  endtask

  task automatic test_proc_range();
    int e_cnt, b_cnt, w_cnt;
    e_cnt = 0; b_cnt = 0; w_cnt = 0;
    @(posedge clk); #1;
    s3_save = 1; s3_pid = 2'd3;
    @(posedge clk); #1;
    s3_save = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s3_err) e_cnt++;
      if (s3_busy) b_cnt++;
      if (s3_mem_we || s3_mem_re) w_cnt++;
    end
    checks++;
    if (e_cnt != 1 || b_cnt != 0 || w_cnt != 0) begin
      errors++;
      $display("FAIL proc_range: err=%0d busy=%0d mem=%0d expected 1 0 0", e_cnt, b_cnt, w_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pc_in = 32'h2B0;
    pulse(1, 0, 2'd0);          // now in SAVE, k=0
    repeat (3) @(posedge clk);  // k=3
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b we=%b state=%0d expected 0 0 0", busy, mem_we, dbg_state);
    end
    wait_cycles(4);
    checks++;
    if (done_cnt != 0 || wa_q.size() != 4 || pl_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_abort: done=%0d writes=%0d pc_load=%0d expected 0 4 0",
               done_cnt, wa_q.size(), pl_cnt);
    end
    // Fresh save of proc 0 after the abort.
    clear_mon();
    pc_in = 32'h4C0;
    push_slot(32'h4C0);
    pulse(1, 0, 2'd0);
    wait_cycles(14);
    checks++;
    if (wa_q.size() != STRIDE || done_cnt != 1) begin
      errors++;
      $display("FAIL resave_count: writes=%0d done=%0d expected %0d 1", wa_q.size(), done_cnt, STRIDE);
    end
    for (int i = 0; i < STRIDE && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'(24 + i) || wd_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL resave_word%0d: addr=%0d data=%h expected addr=%0d data=%h",
                 i, wa_q[i], wd_q[i], 24 + i, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    pc_in = 32'h55;
    pulse(1, 0, 2'd2);
    wait_cycles(2);
    start_restore = 1; proc_id = 2'd1;   // arrives while busy: dropped
    wait_cycles(1);
    start_restore = 0; start_save = 1;   // also dropped
    wait_cycles(1);
    start_save = 0;
    wait_cycles(12);
    checks++;
    if (err_cnt != 0 || wa_q.size() != STRIDE || re_cnt != 0 || done_cnt != 1 || busy_cnt != STRIDE) begin
      errors++;
      $display("FAIL busy_ignore: err=%0d writes=%0d reads=%0d done=%0d busy=%0d expected 0 %0d 0 1 %0d",
               err_cnt, wa_q.size(), re_cnt, done_cnt, busy_cnt, STRIDE, STRIDE);
    end
    checks++;
    if (wa_q.size() > 0 && wa_q[0] !== 32'(24 + 2 * STRIDE)) begin
      errors++; $display("FAIL busy_ignore_base: addr=%0d expected %0d", wa_q[0], 24 + 2 * STRIDE);
    end
  endtask

`ifdef CTX_CHECKSUM_EN
  task automatic test_checksum();
    // Slot 0 holds the 0x4C0 save from test_reset_mid; flip a bit in r2's word.
    @(posedge clk); #1;
    bd_we = 1; bd_addr = 6'd26; bd_data = 32'h102 ^ 32'h1;
    @(posedge clk); #1;
    bd_we = 0;
    clear_mon();
    pulse(0, 1, 2'd0);
    wait_cycles(14);
    checks++;
    if (chk_cnt != 1 || chk_bad != 0 || done_cnt != 1 || pl_cnt != 0) begin
      errors++;
      $display("FAIL checksum: chk_err=%0d stray=%0d done=%0d pc_load=%0d expected 1 0 1 0",
               chk_cnt, chk_bad, done_cnt, pl_cnt);
    end
    checks++;
    if (ra_q.size() != 7) begin
      errors++; $display("FAIL checksum_regs: got %0d expected 7", ra_q.size());
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    clear_mon();
    test_reset();
    test_save();
    test_restore();
    test_both_starts();
    test_proc_range();
    test_reset_mid();
    test_back_to_back();
`ifdef CTX_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctx_switch_unit.md
Name: ctx_switch_unit

Overview:
- Context save/restore sequencer that sits directly upstream of the data memory (memDados).
- On an OS-requested switch, it drives memory address, write data and write enable to dump the leaving process's PC and registers into a per-process slot in data memory.
- On restore, it reads the slot back into the register file and hands the PC to the fetch stage.
- Its PC source is the data memory's saved-PC output (saidaPC).

Parameters:
- DATA_W, 32, data word width.
- NSAVE, 7, registers saved per process; registers 1..NSAVE (r0 never saved).
- NUM_PROC, 4, number of process slots.
- CTX_BASE, 24, first data-memory word of slot 0.
- Constraint: CTX_BASE + NUM_PROC*STRIDE <= 64.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_save  in  1  one-cycle request: save context of proc_id.
- start_restore  in  1  one-cycle request: restore context of proc_id.
- proc_id  in  2  slot index, sampled on the start cycle.
- pc_in  in  32  saved PC from data memory (saidaPC).
- reg_rdata  in  32  register file read data; combinational from reg_raddr.
- reg_raddr  out  5  register file read address.
- reg_we  out  1  register file write enable.
- reg_waddr  out  5  register file write address.
- reg_wdata  out  32  register file write data.
- mem_addr  out  32  data memory address (to posicao).
- mem_wdata  out  32  data memory write data (to dados).
- mem_we  out  1  data memory write enable (to memWrite).
- mem_re  out  1  data memory read enable (to memRead).
- mem_rdata  in  32  data memory read data (saidaDados); combinational from mem_addr.
- pc_out  out  32  restored PC.
- pc_load  out  1  one-cycle strobe: pc_out valid.
- busy  out  1  high while in SAVE or RESTORE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected request.
- chk_err  out  1  checksum mismatch; present only with CTX_CHECKSUM_EN.

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_we, mem_re, reg_we, pc_load, busy, done, err, chk_err, mem_addr, mem_wdata, reg_*, pc_out.
- STRIDE = NSAVE+1 (NSAVE+2 with checksum). base = CTX_BASE + proc_id*STRIDE. proc_id is latched at start.
- States: IDLE, SAVE, RESTORE, FIN. Index counter k counts 0..STRIDE-1.
- IDLE:
  - start_save alone with proc_id<NUM_PROC -> SAVE, k=0.
  - start_restore alone with proc_id<NUM_PROC -> RESTORE, k=0.
  - Both starts high, or proc_id>=NUM_PROC -> err=1 for one cycle; stay IDLE; no memory access.
- SAVE, cycle k:
  - mem_we=1, mem_addr=base+k.
  - k=0: mem_wdata=pc_in.
  - k=1..NSAVE: reg_raddr=k, mem_wdata=reg_rdata.
  - After k=STRIDE-1 -> FIN. SAVE occupies exactly STRIDE cycles.
- RESTORE, cycle k:
  - mem_re=1, mem_addr=base+k.
  - k=0: pc_out<=mem_rdata, registered.
  - k=1..NSAVE: reg_we=1, reg_waddr=k, reg_wdata=mem_rdata.
  - After the last word -> FIN.
- FIN: done=1 for one cycle. pc_load=1 in the same cycle, restore only. -> IDLE.
- busy=1 in SAVE and RESTORE; 0 in IDLE and FIN.
- Start pulses while busy or in FIN are ignored; no err.
- mem_we and mem_re are never high together; reg_we is never high during SAVE.
- Reset mid-operation: abort at the next edge, with no done and no pc_load. Partially written slot contents remain; this is not an error.
- Address arithmetic is unsigned 32-bit with no wrap checking; the parameter constraint guarantees range.

Optional Feature:
- Macro: CTX_CHECKSUM_EN.
- When defined:
  - STRIDE=NSAVE+2.
  - Last SAVE cycle writes the XOR of all STRIDE-1 saved words to base+NSAVE+1.
  - RESTORE reads that word last and compares it with the running XOR.
  - On mismatch, chk_err=1 during FIN alongside done. pc_load is suppressed, but registers are already written.
- When undefined: no checksum word, chk_err port absent, STRIDE=NSAVE+1.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0.
- Save proc 1 with pc_in=0x2B0, reg k=0x100+k -> 8 writes at addr 32..39: 0x2B0, 0x101..0x107. busy for 8 cycles, then done 1 cycle.
- Restore proc 1 after the save above -> reg_we writes r1..r7=0x101..0x107; pc_out=0x2B0, pc_load coincident with done; 0 mem_we cycles.
- start_save and start_restore in the same cycle -> err pulse, busy stays 0, no mem_we. Repeat with proc_id=3 at NUM_PROC=3 -> err.
- Reset asserted in SAVE cycle k=3 -> next cycle IDLE, no done; new save of proc 0 then completes normally at addr 24..31.
- CTX_CHECKSUM_EN: save proc 0, corrupt word 26 via memory backdoor, restore -> chk_err=1 with done, pc_load=0.
